bmem_arbiter: RTL and testbench

- Parametrised N-client line-fill/write-back arbiter between the cache DFP ports and the burst memory (bmem) interface.
- Clients are the OOO and pipeline I/D caches, or any count of them. Each client issues a whole cache-line read or write.
- The block grants clients in fair round-robin order, serialises line traffic into BEATS-beat bursts, and filters returning beats by address.
- Full-line read data goes back on a shared bus, qualified by a one-hot response pulse.

---
 rtl/bmem_arb_pkg.sv | 21 ++
 rtl/bmem_arbiter_rr_pick.sv | 31 +++
 rtl/bmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_arb_pkg.sv
// Shared types and sizing helpers for the bmem line arbiter.
// Imported by the arbiter top and its pick logic.
package bmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_BURST,
    RESP
  } arb_state_t;

  function automatic int beats(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/bmem_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Purely combinational so other arbiters can reuse it.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // scan N slots starting at ptr, keep the first hit
  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// N-client cache line arbiter onto the burst memory port.
// Round-robin grant, beat serialisation, tag-filtered read fill.
module bmem_arbiter
  import bmem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 32,
  parameter int BEAT_W      = 64,
  parameter int LINE_W      = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS-1:0]        cl_read,
  input  logic [NUM_CLIENTS-1:0]        cl_write,
  input  logic [NUM_CLIENTS*LINE_W-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]        cl_resp,
  output logic [LINE_W-1:0]             cl_rdata,
  output logic [ADDR_W-1:0]             bmem_addr,
  output logic                          bmem_read,
  output logic                          bmem_write,
  output logic [BEAT_W-1:0]             bmem_wdata,
  input  logic                          bmem_ready,
  input  logic [ADDR_W-1:0]             bmem_raddr,
  input  logic [BEAT_W-1:0]             bmem_rdata,
  input  logic                          bmem_rvalid
);

  localparam int BEATS = beats(LINE_W, BEAT_W);
  localparam int OFF_W = off_w(LINE_W);
  localparam int IW    = $clog2(NUM_CLIENTS);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

  arb_state_t                            state_q, state_d;
  logic [IW-1:0]                         ptr_q, ptr_d;
  logic [IW-1:0]                         gnt_q, gnt_d;
  logic [CW-1:0]                         beat_q, beat_d;
  logic [ADDR_W-1:0]                     addr_q, addr_d;
  line_t                                 wbuf_q, wbuf_d;
  line_t                                 line_q, line_d;
  logic                                  wr_q, wr_d;

  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]    addr_v;
  logic [NUM_CLIENTS-1:0][LINE_W-1:0]    wdata_v;
  logic [NUM_CLIENTS-1:0]                req;
  logic [NUM_CLIENTS-1:0]                pick_gnt;
  logic [IW-1:0]                         pick_idx;
  logic                                  pick_vld;
  logic                                  last_beat;
  logic                                  tag_hit;
  logic                                  unused_raddr;

  assign addr_v       = cl_addr;
  assign wdata_v      = cl_wdata;
  assign req          = cl_read | cl_write;
  assign last_beat    = (beat_q == CW'(BEATS - 1));
  assign tag_hit      = bmem_rvalid &&
    (bmem_raddr[ADDR_W-1:OFF_W] == addr_q[ADDR_W-1:OFF_W]);
  assign unused_raddr = ^bmem_raddr[OFF_W-1:0];

  rr_pick #(
    .N(NUM_CLIENTS)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_vld)
  );

  // transaction sequencing: grant, command, beats, one-cycle response
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d              = pick_idx;
          addr_d             = addr_v[pick_idx];
          addr_d[OFF_W-1:0]  = '0;
          wbuf_d             = wdata_v[pick_idx];
          wr_d               = |(cl_write & pick_gnt);
          beat_d             = '0;
          state_d            = wr_d ? WR_BURST : RD_CMD;
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (tag_hit) begin
          line_d[beat_q] = bmem_rdata;
          beat_d         = beat_q + 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == IW'(NUM_CLIENTS - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      wr_q    <= wr_d;
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    bmem_addr  = addr_q;
    bmem_read  = (state_q == RD_CMD);
    bmem_write = (state_q == WR_BURST);
    bmem_wdata = '0;
    cl_resp    = '0;
    cl_rdata   = '0;
    if (state_q == WR_BURST) bmem_wdata = wbuf_q[beat_q];
    if (state_q == RESP) begin
      cl_resp[gnt_q] = 1'b1;
      if (!wr_q) cl_rdata = line_q;
    end
  end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter with a reactive memory model.
// Responses are checked against a scoreboard of expected lines.
module tb_bmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 64;
  localparam int LW = 256;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*AW-1:0] cl_addr;
  logic [N-1:0]    cl_read, cl_write, cl_resp;
  logic [N*LW-1:0] cl_wdata;
  logic [LW-1:0]   cl_rdata;
  logic [AW-1:0]   bmem_addr, bmem_raddr;
  logic            bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [BW-1:0]   bmem_wdata, bmem_rdata;

  logic [2*AW-1:0] c2_addr;
  logic [1:0]      c2_read, c2_write, c2_resp;
  logic [1023:0]   c2_wdata;
  logic [511:0]    c2_rdata;
  logic [AW-1:0]   c2_baddr;
  logic            c2_bread, c2_bwrite;
  logic [BW-1:0]   c2_bwdata;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cl_addr(cl_addr), .cl_read(cl_read), .cl_write(cl_write),
    .cl_wdata(cl_wdata), .cl_resp(cl_resp), .cl_rdata(cl_rdata),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  bmem_arbiter #(
    .NUM_CLIENTS(2), .ADDR_W(32), .BEAT_W(64), .LINE_W(512)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cl_addr(c2_addr), .cl_read(c2_read), .cl_write(c2_write),
    .cl_wdata(c2_wdata), .cl_resp(c2_resp), .cl_rdata(c2_rdata),
    .bmem_addr(c2_baddr), .bmem_read(c2_bread),
    .bmem_write(c2_bwrite), .bmem_wdata(c2_bwdata),
    .bmem_ready(1'b1), .bmem_raddr(32'h0),
    .bmem_rdata(64'h0), .bmem_rvalid(1'b0)
  );

  typedef struct {
    int          client;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] wlog[$];
  int            checks = 0;
  int            errors = 0;

  int            rd_left, rd_k, wcyc, rd_cmds;
  logic [AW-1:0] rd_addr;
  bit            inj_en, injected, stall_en, stalled_prev;
  logic [BW-1:0] prev_wd;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] bv(input logic [AW-1:0] a,
                                       input int k);
    return {a, 16'hBEEF, 8'(k), 8'h5A};
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = bv(a & ~32'h1F, k);
    return l;
  endfunction

  function automatic logic [LW-1:0] mk_line(input logic [15:0] s);
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = {16'hC0DE, s, 32'(k)};
    return l;
  endfunction

  task automatic req_read(input int c, input logic [AW-1:0] a);
    cl_addr[c*AW +: AW] = a;
    cl_read[c] = 1'b1;
    exp_q.push_back('{c, line_of(a)});
  endtask

  task automatic req_write(input int c, input logic [AW-1:0] a,
                           input logic [LW-1:0] d);
    cl_addr[c*AW +: AW]  = a;
    cl_wdata[c*LW +: LW] = d;
    cl_write[c] = 1'b1;
    exp_q.push_back('{c, '0});
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_resp"},   cl_resp,    0);
    chk({tag, "_rdata"},  cl_rdata,   0);
    chk({tag, "_baddr"},  bmem_addr,  0);
    chk({tag, "_bread"},  bmem_read,  0);
    chk({tag, "_bwrite"}, bmem_write, 0);
    chk({tag, "_bwdata"}, bmem_wdata, 0);
  endtask

  task automatic chk_wlog(input string tag, input logic [LW-1:0] d);
    chk({tag, "_nbeats"}, wlog.size(), NB);
    for (int k = 0; k < NB && k < wlog.size(); k++)
      chk({tag, "_beat"}, wlog[k], d[k*BW +: BW]);
  endtask

  // memory model: ready/stall, write log, read beat return
  initial begin
    bmem_ready = 1'b1; bmem_rvalid = 1'b0;
    bmem_raddr = '0; bmem_rdata = '0;
    rd_left = 0; rd_k = 0; wcyc = 0; rd_cmds = 0;
    stalled_prev = 1'b0; injected = 1'b0;
    forever begin
      @(negedge clk);
      bmem_rvalid = 1'b0;
      if (!rst) begin
        rd_left = 0; wcyc = 0; bmem_ready = 1'b1; stalled_prev = 1'b0;
      end else begin
        if (bmem_write) begin
          wcyc++;
          if (stalled_prev) chk("stall_hold", bmem_wdata, prev_wd);
          bmem_ready = !(stall_en && (wcyc == 2 || wcyc == 4));
          stalled_prev = !bmem_ready;
          prev_wd = bmem_wdata;
          if (bmem_ready) wlog.push_back(bmem_wdata);
        end else begin
          wcyc = 0; bmem_ready = 1'b1; stalled_prev = 1'b0;
        end
        if (rd_left > 0) begin
          bmem_rvalid = 1'b1;
          if (inj_en && rd_k == 2 && !injected) begin
            injected = 1'b1;
            bmem_raddr = 32'h0000_4000;
            bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
          end else begin
            bmem_raddr = rd_addr;
            bmem_rdata = bv(rd_addr, rd_k);
            rd_k++;
            rd_left--;
          end
        end
        if (bmem_read && bmem_ready) begin
          rd_cmds++;
          rd_addr = bmem_addr;
          rd_left = NB; rd_k = 0; injected = 1'b0;
        end
      end
    end
  end

  // scoreboard: compare each response pulse, client then drops request
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && cl_resp != '0) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", cl_resp, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_onehot", cl_resp, 4'(1) << e.client);
          chk("resp_rdata", cl_rdata, e.rdata);
        end
        cl_read  = cl_read & ~cl_resp;
        cl_write = cl_write & ~cl_resp;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] wd;
    logic [1:0]    exp_g;
    logic [BW-1:0] first;
    logic [AW-1:0] baddr;
    int            nresp, nbeat, nrd;

    rst = 1'b0;
    cl_addr = '0; cl_read = '0; cl_write = '0; cl_wdata = '0;
    c2_addr = '0; c2_read = '0; c2_write = '0; c2_wdata = '0;
    stall_en = 1'b0; inj_en = 1'b0;
    #1;
    chk_outs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single read, client 2, unaligned address
    rd_cmds = 0;
    req_read(2, 32'h0000_1234);
    wait_drain("t1_drain");
    chk("t1_baddr", rd_addr, 32'h0000_1220);
    chk("t1_rdcmds", rd_cmds, 1);

    // client 3 read with a foreign-tagged beat injected
    inj_en = 1'b1;
    req_read(3, 32'h0000_8060);
    wait_drain("t4_drain");
    inj_en = 1'b0;

    // all four read, ptr now 0; client 0 re-requests after its resp
    for (int c = 0; c < N; c++) req_read(c, 32'h0001_0000 + 32'(c) * 32'h100);
    for (int i = 0; i < 100 && !cl_resp[0]; i++) @(negedge clk);
    @(negedge clk);
    req_read(0, 32'h0002_0040);
    wait_drain("t2_drain");

    // client 1 write with stalls on burst cycles 2 and 4
    stall_en = 1'b1;
    wlog.delete();
    wd = mk_line(16'h0001);
    req_write(1, 32'h0000_3000, wd);
    wait_drain("t3_drain");
    stall_en = 1'b0;
    chk_wlog("t3", wd);

    // async reset after beat 1 of a client 0 write, then restart
    wlog.delete();
    wd = mk_line(16'h0005);
    req_write(0, 32'h0000_5008, wd);
    for (int i = 0; i < 50 && wlog.size() < 2; i++) @(negedge clk);
    chk("t5_reach_beat1", wlog.size(), 2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_outs_zero("t5_mid");
    @(negedge clk);
    wlog.delete();
    #2 rst = 1'b1;
    wait_drain("t5_drain");
    chk_wlog("t5", wd);

    // two-client 512-bit build: 8-beat writes, alternating grants
    c2_addr  = {32'h0000_10C7, 32'h0000_007F};
    for (int k = 0; k < 16; k++) c2_wdata[k*64 +: 64] = {32'hFACE_0000, 32'(k)};
    c2_write = 2'b11;
    exp_g = 2'b01; nresp = 0; nbeat = 0; nrd = 0;
    first = '0; baddr = '0;
    for (int i = 0; i < 150 && nresp < 3; i++) begin
      @(negedge clk);
      if (c2_bread) nrd++;
      if (c2_bwrite) begin
        if (nbeat == 0) begin
          first = c2_bwdata;
          baddr = c2_baddr;
        end
        nbeat++;
      end
      if (c2_resp != '0) begin
        chk("u2_grant", c2_resp, exp_g);
        chk("u2_beats", nbeat, 8);
        chk("u2_addr", baddr, exp_g[0] ? 32'h0000_0040 : 32'h0000_10C0);
        chk("u2_beat0", first, exp_g[0] ? c2_wdata[63:0] : c2_wdata[575:512]);
        chk("u2_rdata", c2_rdata, 0);
        exp_g = ~exp_g;
        nbeat = 0;
        nresp++;
      end
    end
    chk("u2_nresp", nresp, 3);
    chk("u2_noread", nrd, 0);
    c2_write = 2'b00;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
